// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and defaults for the instruction fetch queue.
// A FIFO entry pairs the instruction with the address of the instruction after it.
package instr_fetch_queue_pkg;

    typedef struct packed {
        logic [31:0] pc_plus_four;
        logic [31:0] instr;
    } ifq_entry_t;

    localparam int          IFQ_DEPTH    = 4;
    localparam logic [31:0] IFQ_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Bundles the instruction-memory and dispatcher-facing signals of the fetch queue.
// The master side belongs to the fetch queue; the slave side is the memory plus dispatcher.
interface instr_fetch_queue_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        dispatch_ren;
    logic        dispatch_jump_branch;
    logic [31:0] dispatch_jmp_branch_addr;
    logic [31:0] ifetch_instruction;
    logic [31:0] ifetch_pc_plus_four;
    logic        ifetch_empty_flag;
    logic        ifq_full;

    modport master (
        output imem_req, imem_addr, ifetch_instruction, ifetch_pc_plus_four,
               ifetch_empty_flag, ifq_full,
        input  imem_rdata, dispatch_ren, dispatch_jump_branch, dispatch_jmp_branch_addr
    );

    modport slave (
        input  imem_req, imem_addr, ifetch_instruction, ifetch_pc_plus_four,
               ifetch_empty_flag, ifq_full,
        output imem_rdata, dispatch_ren, dispatch_jump_branch, dispatch_jmp_branch_addr
    );

endinterface

// File: rtl/instr_fetch_queue_fifo_mem.sv
// Register-array storage for the fetch queue; the head entry is read combinationally
// so the dispatcher sees a newly written entry in the cycle right after the write.
module ifq_fifo_mem
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  ifq_entry_t    wr_data,
    input  logic [AW-1:0] rd_addr,
    output ifq_entry_t    head
);

    ifq_entry_t mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (we) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    assign head = mem_reg[rd_addr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetch with a small {PC+4, instruction} FIFO toward the dispatcher.
// A jump/branch from the dispatcher flushes buffered and in-flight work and redirects fetch.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = IFQ_DEPTH,
    parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_queue_if.master bus
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    logic [AW:0]  rd_ptr_reg;
    logic [AW:0]  wr_ptr_reg;
    logic [31:0]  fetch_pc_reg;
    logic [31:0]  pend_pc_reg;
    logic         pend_valid_reg;

    logic [AW:0]  count;
    logic [AW+1:0] occupancy;
    logic         empty;
    logic         full;
    logic         req;
    logic         wr_en;
    logic         pop;
    logic         clr;
    ifq_entry_t   wr_data;
    ifq_entry_t   head;

    assign count     = wr_ptr_reg - rd_ptr_reg;
    assign empty     = (rd_ptr_reg == wr_ptr_reg);
    assign full      = (rd_ptr_reg[AW] != wr_ptr_reg[AW]) &&
                       (rd_ptr_reg[AW-1:0] == wr_ptr_reg[AW-1:0]);

    // The outstanding read already owns a slot; a same-cycle pop earns no credit.
    assign occupancy = {1'b0, count} + {{(AW+1){1'b0}}, pend_valid_reg};
    assign req       = !rst && !bus.dispatch_jump_branch && (occupancy < DEPTH_W);

    assign wr_en     = pend_valid_reg && !full && !clr;
    assign pop       = bus.dispatch_ren && !empty;
    assign clr       = rst || bus.dispatch_jump_branch;
    assign wr_data   = '{pc_plus_four: pend_pc_reg + 32'd4, instr: bus.imem_rdata};

    ifq_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .clr     (clr),
        .we      (wr_en),
        .wr_addr (wr_ptr_reg[AW-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_reg[AW-1:0]),
        .head    (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            pend_valid_reg <= 1'b0;
            pend_pc_reg    <= '0;
            fetch_pc_reg   <= RESET_PC;
        end else if (bus.dispatch_jump_branch) begin
            // Data returning next cycle belongs to a killed request.
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            pend_valid_reg <= 1'b0;
            fetch_pc_reg   <= bus.dispatch_jmp_branch_addr;
        end else begin
            assert (!(pend_valid_reg && full));
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            pend_valid_reg <= req;
            if (req) begin
                pend_pc_reg  <= fetch_pc_reg;
                fetch_pc_reg <= fetch_pc_reg + 32'd4;
            end
        end
    end

    assign bus.imem_req            = req;
    assign bus.imem_addr           = fetch_pc_reg;
    assign bus.ifetch_instruction  = empty ? 32'd0 : head.instr;
    assign bus.ifetch_pc_plus_four = empty ? 32'd0 : head.pc_plus_four;
    assign bus.ifetch_empty_flag   = empty;
    assign bus.ifq_full            = full;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed and randomized bench for the fetch queue against a transaction-level model
// built from a queue of expected entries, a fetch PC and one outstanding-read slot.
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] instr;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_queue_if bus ();

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    ent_t        mq[$];
    logic [31:0] m_fpc;
    logic        m_pv;
    logic [31:0] m_ppc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Synchronous instruction memory; unrequested cycles return junk.
    always @(posedge clk) begin
        bus.imem_rdata <= bus.imem_req ? mem_word(bus.imem_addr) : $urandom;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc = RESET_PC;
        m_pv  = 1'b0;
        m_ppc = '0;
    endtask

    task automatic step(input logic r, input logic ren, input logic jb, input logic [31:0] tgt);
        logic exp_req;
        logic do_pop;
        logic do_wr;
        ent_t hd;
        @(negedge clk);
        rst                          = r;
        bus.dispatch_ren             = ren;
        bus.dispatch_jump_branch     = jb;
        bus.dispatch_jmp_branch_addr = tgt;
        #1;
        exp_req = !r && !jb && ((mq.size() + int'(m_pv)) < DEPTH);
        check("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
        if (exp_req) check("imem_addr", bus.imem_addr, m_fpc);
        check("empty", {31'd0, bus.ifetch_empty_flag}, {31'd0, mq.size() == 0});
        check("full", {31'd0, bus.ifq_full}, {31'd0, mq.size() == DEPTH});
        if (mq.size() > 0) hd = mq[0];
        else hd = '{pc4: 32'd0, instr: 32'd0};
        check("head_instr", bus.ifetch_instruction, hd.instr);
        check("head_pc4", bus.ifetch_pc_plus_four, hd.pc4);
        @(posedge clk);
        if (r) begin
            $display("reset");
            model_reset();
        end else if (jb) begin
            $display("flush target=%h", tgt);
            mq.delete();
            m_pv  = 1'b0;
            m_fpc = tgt;
        end else begin
            do_pop = ren && (mq.size() > 0);
            do_wr  = m_pv && (mq.size() < DEPTH);
            if (do_pop) begin
                $display("pop pc4=%h instr=%h", mq[0].pc4, mq[0].instr);
                void'(mq.pop_front());
            end
            if (do_wr) mq.push_back('{pc4: m_ppc + 32'd4, instr: mem_word(m_ppc)});
            m_pv = exp_req;
            if (exp_req) begin
                m_ppc = m_fpc;
                m_fpc = m_fpc + 32'd4;
            end
        end
    endtask

    initial begin
        bus.dispatch_ren             = 1'b0;
        bus.dispatch_jump_branch     = 1'b0;
        bus.dispatch_jmp_branch_addr = '0;
        model_reset();
        @(posedge clk);

        // Reset held two cycles, then fill with no reads until throttled
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (10) step(0, 0, 0, 0);

        // Streaming drain and refill
        repeat (20) step(0, 1, 0, 0);

        // Redirect with three entries buffered and a read pending
        step(1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        step(0, 0, 1, 32'h0000_0040);
        repeat (6) step(0, 0, 0, 0);
        repeat (4) step(0, 1, 0, 0);

        // Flush and pop in the same cycle with two entries
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 1, 32'h0000_0100);
        repeat (5) step(0, 1, 0, 0);

        // Back-to-back flushes: last target wins
        step(0, 1, 1, 32'h0000_0200);
        step(0, 0, 1, 32'h0000_0300);
        repeat (5) step(0, 1, 0, 0);

        // Reset while full-ish with a read outstanding
        repeat (4) step(0, 0, 0, 0);
        step(1, 1, 1, 32'h0000_0500);
        repeat (8) step(0, 1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic r;
            logic jb;
            logic ren;
            r   = ($urandom_range(0, 149) == 0);
            jb  = ($urandom_range(0, 11) == 0);
            ren = ($urandom_range(0, 2) != 0);
            step(r, ren, jb, $urandom & 32'hFFFF_FFFC);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
